// File: rtl/rx_text_pkg.sv
// Shared definitions for the RS232 text buffer:
// control codes, sweep states and the fill character.
package rx_text_pkg;

  localparam logic [6:0] CH_BS = 7'h08;
  localparam logic [6:0] CH_LF = 7'h0A;
  localparam logic [6:0] CH_FF = 7'h0C;
  localparam logic [6:0] CH_CR = 7'h0D;

  localparam logic [7:0] BLANK_CH = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    SCROLL,
    BLANKROW,
    CLEAR
  } state_t;

  function automatic int cell_idx(
    input int row,
    input int col,
    input int cols
  );
    return row * cols + col;
  endfunction

endpackage

// File: rtl/rx_strobe_hold.sv
// UART strobe edge detector with a one-entry hold for
// bytes arriving during a sweep, plus the sticky drop flag.
module rx_strobe_hold (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic [7:0] i_data,
  input  logic       i_busy,
  input  logic       i_ovf_clr,
  output logic       o_vld,
  output logic [7:0] o_byte,
  output logic       o_ovf
);

  logic       r_en_d0;
  logic       r_en_d1;
  logic       r_pend_vld;
  logic [7:0] r_pend_byte;
  logic       r_ovf;
  logic       w_evt;
  logic       w_hold;
  logic       w_drop;

  assign w_evt = r_en_d0 & ~r_en_d1;

  // Held byte goes first; a fresh byte in that cycle takes its slot.
  assign w_hold = w_evt & (i_busy ? ~r_pend_vld : r_pend_vld);
  assign w_drop = w_evt & i_busy & r_pend_vld;

  assign o_vld  = ~i_busy & (r_pend_vld | w_evt);
  assign o_byte = r_pend_vld ? r_pend_byte : i_data;
  assign o_ovf  = r_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en_d0     <= 1'b0;
      r_en_d1     <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_byte <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_en_d0 <= i_en;
      r_en_d1 <= r_en_d0;
      if (w_hold) begin
        r_pend_vld  <= 1'b1;
        r_pend_byte <= i_data;
      end else if (!i_busy) begin
        r_pend_vld <= 1'b0;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rx_text_buffer.sv
// ROWS x COLS character store with cursor, auto-wrap,
// cell-per-cycle scroll/clear sweeps and a registered read port.
module rx_text_buffer
  import rx_text_pkg::*;
#(
  parameter int         COLS  = 16,
  parameter int         ROWS  = 2,
  parameter logic [7:0] BLANK = BLANK_CH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    RS232_EN,
  input  logic [7:0]              RX_DATA,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  input  logic [$clog2(COLS)-1:0] rd_col,
  output logic [7:0]              rd_data,
  output logic [$clog2(ROWS)-1:0] cur_row,
  output logic [$clog2(COLS)-1:0] cur_col,
  output logic                    busy,
  output logic                    ovf,
  output logic                    wr_evt
);

  localparam int RW      = $clog2(ROWS);
  localparam int CW      = $clog2(COLS);
  localparam int N       = ROWS * COLS;
  localparam int IW      = $clog2(N);
  localparam int SCR_END = COLS * (ROWS - 1) - 1;

  state_t        r_state;
  state_t        w_state_nx;
  logic [RW-1:0] r_row;
  logic [RW-1:0] w_row_nx;
  logic [CW-1:0] r_col;
  logic [CW-1:0] w_col_nx;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idx_nx;
  logic [7:0]    r_mem [N];
  logic [7:0]    r_rd_data;
  logic          r_wr_evt;

  logic          w_vld;
  logic [7:0]    w_byte;
  logic [6:0]    w_code;
  logic          w_is_cr;
  logic          w_is_ff;
  logic          w_is_bs;
  logic          w_is_lf;
  logic          w_is_chr;
  logic          w_last_row;
  logic          w_last_col;
  logic          w_scr_done;
  logic          w_sweep_end;
  logic [IW-1:0] w_cur_idx;
  logic [IW-1:0] w_rd_idx;
  logic [IW-1:0] w_src;
  logic          w_we;
  logic [IW-1:0] w_waddr;
  logic [7:0]    w_wdata;
  logic          w_ovf_clr;

  rx_strobe_hold u_hold (
    .clk      (clk),
    .reset    (reset),
    .i_en     (RS232_EN),
    .i_data   (RX_DATA),
    .i_busy   (busy),
    .i_ovf_clr(w_ovf_clr),
    .o_vld    (w_vld),
    .o_byte   (w_byte),
    .o_ovf    (ovf)
  );

  assign w_code   = w_byte[6:0];
  assign w_is_cr  = (w_code == CH_CR);
  assign w_is_ff  = (w_code == CH_FF);
  assign w_is_bs  = (w_code == CH_BS);
  assign w_is_lf  = (w_code == CH_LF);
  assign w_is_chr = ~(w_is_cr | w_is_ff | w_is_bs | w_is_lf);

  assign w_last_row  = (r_row == RW'(ROWS - 1));
  assign w_last_col  = (r_col == CW'(COLS - 1));
  assign w_scr_done  = (r_idx == IW'(SCR_END));
  assign w_sweep_end = (r_idx == IW'(N - 1));

  assign w_cur_idx = IW'(cell_idx(int'(r_row), int'(r_col), COLS));
  assign w_rd_idx  = IW'(cell_idx(int'(rd_row), int'(rd_col), COLS));
  assign w_src     = r_idx + IW'(COLS);

  assign busy    = (r_state != IDLE);
  assign cur_row = r_row;
  assign cur_col = r_col;
  assign rd_data = r_rd_data;
  assign wr_evt  = r_wr_evt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_row   <= w_row_nx;
      r_col   <= w_col_nx;
      r_idx   <= w_idx_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_vld && w_is_ff) begin
          w_state_nx = CLEAR;
        end else if (w_vld && w_is_cr && w_last_row) begin
          w_state_nx = SCROLL;
        end else if (w_vld && w_is_chr && w_last_row && w_last_col) begin
          w_state_nx = SCROLL;
        end
      end
      SCROLL:   if (w_scr_done) w_state_nx = BLANKROW;
      BLANKROW: if (w_sweep_end) w_state_nx = IDLE;
      CLEAR:    if (w_sweep_end) w_state_nx = IDLE;
    endcase
  end

  always_comb begin
    w_we      = 1'b0;
    w_waddr   = w_cur_idx;
    w_wdata   = w_byte;
    w_row_nx  = r_row;
    w_col_nx  = r_col;
    w_idx_nx  = '0;
    w_ovf_clr = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_vld) begin
          unique case (1'b1)
            w_is_cr: begin
              w_col_nx = '0;
              if (!w_last_row) w_row_nx = r_row + RW'(1);
            end
            w_is_bs: begin
              if (r_col != '0) begin
                w_col_nx = r_col - CW'(1);
                w_we     = 1'b1;
                w_waddr  = w_cur_idx - IW'(1);
                w_wdata  = BLANK;
              end
            end
            w_is_chr: begin
              w_we = 1'b1;
              if (w_last_col) begin
                w_col_nx = '0;
                if (!w_last_row) w_row_nx = r_row + RW'(1);
              end else begin
                w_col_nx = r_col + CW'(1);
              end
            end
            default: ;
          endcase
        end
      end
      // Ascending copy: each source cell is read before it is overwritten.
      SCROLL: begin
        w_we     = 1'b1;
        w_waddr  = r_idx;
        w_wdata  = r_mem[w_src];
        w_idx_nx = r_idx + IW'(1);
      end
      BLANKROW: begin
        w_we     = 1'b1;
        w_waddr  = r_idx;
        w_wdata  = BLANK;
        w_idx_nx = r_idx + IW'(1);
        if (w_sweep_end) begin
          w_row_nx = RW'(ROWS - 1);
          w_col_nx = '0;
        end
      end
      CLEAR: begin
        w_we     = 1'b1;
        w_waddr  = r_idx;
        w_wdata  = BLANK;
        w_idx_nx = r_idx + IW'(1);
        if (w_sweep_end) begin
          w_row_nx  = '0;
          w_col_nx  = '0;
          w_ovf_clr = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) r_mem[i] <= BLANK;
      r_rd_data <= BLANK;
      r_wr_evt  <= 1'b0;
    end else begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
      r_rd_data <= r_mem[w_rd_idx];
      r_wr_evt  <= w_we;
    end
  end

endmodule
